win3x3_gen: RTL and testbench
=============================

Name: win3x3_gen

Overview:
- Streaming 3x3 window generator. Sits directly upstream of the dead-pixel corrector and drives its in3x3_* interface.
- Accepts 1 pixel/cycle with frame markers, stores two previous lines in line buffers, and emits one full 3x3 neighbourhood per accepted pixel once two lines and two columns are available.
- Output frame is (W-2)x(H-2). No border replication.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- MAX_WIDTH, 1024, maximum line length in pixels; sets line buffer depth.
- COL_W, 11, column/row counter width; must satisfy 2^COL_W > MAX_WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_val  in  1  upstream pixel valid.
- in_rdy  out  1  block can accept a pixel.
- in_data  in  DATA_WIDTH  pixel value.
- in_sof  in  1  start of frame; qualifies first pixel of frame.
- in_sol  in  1  start of line.
- in_eol  in  1  end of line.
- in_eof  in  1  end of frame.
- out3x3_val  out  1  window valid.
- out3x3_rdy  in  1  downstream ready.
- out3x3_data  out  9*DATA_WIDTH  window, p00 at MSBs down to p22 at LSBs; row 0 = oldest line, col 0 = leftmost.
- out3x3_sof / out3x3_sol / out3x3_eol / out3x3_eof  out  1 each  markers of the emitted window.

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Counters col_cnt and row_cnt are 0.
  - Window registers are 0.
  - Line buffer contents are not reset.
- Handshake:
  - acc = in_val & in_rdy.
  - in_rdy = out3x3_rdy | ~out3x3_val (single output register, no skid buffer).
  - Output holds data and markers stable while out3x3_val & ~out3x3_rdy.
- Position of the accepted pixel:
  - col_cur = in_sol ? 0 : col_cnt.
  - row_cur = in_sof ? 0 : row_cnt.
- Counter update on acc:
  - col_cnt <= in_eol ? 0 : min(col_cur+1, MAX_WIDTH-1).
  - row_cnt <= in_eol ? sat(row_cur+1) : row_cur.
- Line buffers lb0 (previous line) and lb1 (line before that):
  - Asynchronous-read arrays addressed by col_cur.
  - On acc: lb1[col_cur] <= lb0[col_cur], lb0[col_cur] <= in_data.
  - Reads use pre-write contents.
- Window registers, 3 columns x 3 rows:
  - On acc, shift left by one column.
  - New right column = {lb1[col_cur], lb0[col_cur], in_data} (rows 0, 1, 2).
- Emit condition: emit = acc & row_cur>=2 & col_cur>=2.
  - On emit, out3x3_val <= 1.
  - The new window drives out3x3_data one cycle after acceptance (latency 1).
  - Markers registered with the window:
    - sof = (row_cur==2 & col_cur==2)
    - sol = (col_cur==2)
    - eol = in_eol
    - eof = in_eof
- Clearing out3x3_val:
  - Cleared when out3x3_rdy & out3x3_val and no new emit in the same cycle.
  - Simultaneous consume and emit: out3x3_val stays 1, new data loads.
- Non-emitting accepts (rows 0-1, cols 0-1) update buffers, counters and window only; output is untouched.
- Boundary conditions:
  - in_sof mid-frame restarts at row 0 col 0. Stale buffer data is never emitted because rows 0-1 do not emit.
  - Line longer than MAX_WIDTH: col saturates at MAX_WIDTH-1, and extra pixels overwrite that entry. Output is undefined for that line but the block does not lock up.
  - Width < 3 or height < 3: no windows emitted, no out3x3_sof.
  - in_eof is passed only if its row emits.
  - Reset mid-frame: output is dropped immediately; the block waits for the next in_sof. Pixels before it are treated as row 0 onward.

Decomposition:
- Shared package win_pkg:
  - default DATA_WIDTH;
  - window tap index constants P00..P22 (slice offsets 8..0);
  - helper function for a 9-pixel slice.
- One sub-module, win_line_buf: parameterised depth/width, async read, one write port.
- The block instantiates win_line_buf twice.

Test Plan:
- 5x4 frame, pixel = 10*row+col, out3x3_rdy=1 -> 6 windows. First window is 0,1,2,10,11,12,20,21,22 with sof=sol=1. Third window has eol=1 and p22=24. Last window has p22=34 and eol=eof=1.
- Same frame, out3x3_rdy toggled 1/0 every cycle -> in_rdy drops while output is stalled. Window sequence identical, no drops or duplicates, data stable during stall.
- 3x3 frame -> exactly one window, with sof=sol=eol=eof=1 all set and data 0..22.
- Second 5x4 frame after a first frame of all 0xFF -> windows contain only second-frame values.
- in_sof at row 1 col 3 of a frame -> no emit until new row 2 col 2. First emitted window is built only from post-sof pixels.
- rst asserted one cycle at row 3 mid-line with out3x3_val=1 -> next cycle out3x3_val=0 and all markers 0. Subsequent frame output matches scenario 1.

Source files
------------

// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 window generator.
// Contents: default pixel width, window tap slot offsets (p00 at the MSBs
// down to p22 at the LSBs), a (row, col) -> slot mapping and a helper that
// extracts one pixel from a flattened 9-pixel window.
package win_pkg;

    localparam int unsigned WIN_DATA_WIDTH = 8;

    // Slot offsets inside a flattened window, in units of one pixel.
    localparam int unsigned P00 = 8;
    localparam int unsigned P01 = 7;
    localparam int unsigned P02 = 6;
    localparam int unsigned P10 = 5;
    localparam int unsigned P11 = 4;
    localparam int unsigned P12 = 3;
    localparam int unsigned P20 = 2;
    localparam int unsigned P21 = 1;
    localparam int unsigned P22 = 0;

    // Row 0 is the oldest line, column 0 the leftmost pixel.
    function automatic int unsigned win_slot(input int unsigned row, input int unsigned col);
        return 8 - (3 * row + col);
    endfunction

    function automatic logic [WIN_DATA_WIDTH-1:0] win_pix(
        input logic [9*WIN_DATA_WIDTH-1:0] win,
        input int unsigned                 slot
    );
        return win[slot*WIN_DATA_WIDTH +: WIN_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/win_line_buf.sv
// Single line buffer: asynchronous read, one synchronous write port.
// Contents are not reset.
// Ports:
//   clk      - clock
//   i_we     - write enable
//   i_addr   - shared read/write address
//   i_wdata  - write data
//   o_rdata  - read data (pre-write contents at i_addr)
module win_line_buf #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/win3x3_gen.sv
// Streaming 3x3 window generator. Accepts one pixel per cycle with frame
// markers, keeps the two previous lines in line buffers and emits one 3x3
// neighbourhood per accepted pixel once two lines and two columns exist.
// Output frame is (W-2)x(H-2), no border replication.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_val/in_rdy/in_data    - pixel input handshake and data
//   in_sof/sol/eol/eof       - input frame markers
//   out3x3_val/out3x3_rdy    - window output handshake
//   out3x3_data              - window, p00 at MSBs .. p22 at LSBs
//   out3x3_sof/sol/eol/eof   - markers of the emitted window
module win3x3_gen
    import win_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WIN_DATA_WIDTH,
    parameter int unsigned MAX_WIDTH  = 1024,
    parameter int unsigned COL_W      = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_sof,
    input  logic                    in_sol,
    input  logic                    in_eol,
    input  logic                    in_eof,
    output logic                    out3x3_val,
    input  logic                    out3x3_rdy,
    output logic [9*DATA_WIDTH-1:0] out3x3_data,
    output logic                    out3x3_sof,
    output logic                    out3x3_sol,
    output logic                    out3x3_eol,
    output logic                    out3x3_eof
);

    localparam int unsigned      LB_AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH - 1);
    localparam logic [COL_W-1:0] TWO     = COL_W'(2);

    logic [COL_W-1:0]        r_col_cnt, r_row_cnt;
    logic [COL_W-1:0]        w_col_cur, w_row_cur;
    logic                    w_acc, w_emit;
    logic [DATA_WIDTH-1:0]   w_lb0_rd, w_lb1_rd;
    logic [DATA_WIDTH-1:0]   r_win     [3][3];   // [row][col]
    logic [DATA_WIDTH-1:0]   w_win_nxt [3][3];
    logic [9*DATA_WIDTH-1:0] w_win_flat;
    logic [9*DATA_WIDTH-1:0] r_out_data;
    logic                    r_out_val;
    logic                    r_out_sof, r_out_sol, r_out_eol, r_out_eof;

    assign in_rdy    = out3x3_rdy | ~r_out_val;
    assign w_acc     = in_val & in_rdy;
    assign w_col_cur = in_sol ? '0 : r_col_cnt;
    assign w_row_cur = in_sof ? '0 : r_row_cnt;
    assign w_emit    = w_acc && (w_row_cur >= TWO) && (w_col_cur >= TWO);

    // lb0 holds the previous line; lb1 takes lb0's old entry, so both
    // shift down one line per accepted pixel at the same column.
    win_line_buf #(
        .DEPTH (MAX_WIDTH),
        .WIDTH (DATA_WIDTH),
        .AW    (LB_AW)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_addr  (w_col_cur[LB_AW-1:0]),
        .i_wdata (in_data),
        .o_rdata (w_lb0_rd)
    );

    win_line_buf #(
        .DEPTH (MAX_WIDTH),
        .WIDTH (DATA_WIDTH),
        .AW    (LB_AW)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_addr  (w_col_cur[LB_AW-1:0]),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    always_comb begin
        w_win_flat = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 2; c++) begin
                w_win_nxt[r][c] = r_win[r][c+1];
            end
        end
        w_win_nxt[0][2] = w_lb1_rd;
        w_win_nxt[1][2] = w_lb0_rd;
        w_win_nxt[2][2] = in_data;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                w_win_flat[win_slot(r, c)*DATA_WIDTH +: DATA_WIDTH] = w_win_nxt[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_acc) begin
            // Column saturates so over-long lines keep rewriting the last entry.
            if (in_eol) begin
                r_col_cnt <= '0;
            end else if (w_col_cur >= COL_MAX) begin
                r_col_cnt <= COL_MAX;
            end else begin
                r_col_cnt <= w_col_cur + 1'b1;
            end
            if (in_eol) begin
                r_row_cnt <= (&w_row_cur) ? w_row_cur : w_row_cur + 1'b1;
            end else begin
                r_row_cnt <= w_row_cur;
            end
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    r_win[r][c] <= w_win_nxt[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_val  <= 1'b0;
            r_out_data <= '0;
            r_out_sof  <= 1'b0;
            r_out_sol  <= 1'b0;
            r_out_eol  <= 1'b0;
            r_out_eof  <= 1'b0;
        end else if (w_emit) begin
            r_out_val  <= 1'b1;
            r_out_data <= w_win_flat;
            r_out_sof  <= (w_row_cur == TWO) && (w_col_cur == TWO);
            r_out_sol  <= (w_col_cur == TWO);
            r_out_eol  <= in_eol;
            r_out_eof  <= in_eof;
        end else if (out3x3_rdy && r_out_val) begin
            r_out_val  <= 1'b0;
        end
    end

    assign out3x3_val  = r_out_val;
    assign out3x3_data = r_out_data;
    assign out3x3_sof  = r_out_sof;
    assign out3x3_sol  = r_out_sol;
    assign out3x3_eol  = r_out_eol;
    assign out3x3_eof  = r_out_eof;

endmodule

// File: tb/tb_win3x3_gen.sv
`timescale 1ns/1ps
module tb_win3x3_gen;
    import win_pkg::*;

    localparam int DW = WIN_DATA_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_val, in_rdy;
    logic [DW-1:0]   in_data;
    logic            in_sof, in_sol, in_eol, in_eof;
    logic            out3x3_val, out3x3_rdy;
    logic [9*DW-1:0] out3x3_data;
    logic            out3x3_sof, out3x3_sol, out3x3_eol, out3x3_eof;

    always #5 clk = ~clk;

    win3x3_gen #(
        .DATA_WIDTH (DW),
        .MAX_WIDTH  (1024),
        .COL_W      (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .in_sol      (in_sol),
        .in_eol      (in_eol),
        .in_eof      (in_eof),
        .out3x3_val  (out3x3_val),
        .out3x3_rdy  (out3x3_rdy),
        .out3x3_data (out3x3_data),
        .out3x3_sof  (out3x3_sof),
        .out3x3_sol  (out3x3_sol),
        .out3x3_eol  (out3x3_eol),
        .out3x3_eof  (out3x3_eof)
    );

    typedef struct packed {
        logic [9*DW-1:0] data;
        logic            sof, sol, eol, eof;
    } win_t;

    win_t exp_q[$];
    win_t log_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: toggle every cycle

    // Reference image of the current frame, indexed by position.
    int   img [16][16];
    int   m_row = 0;
    int   m_col = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Downstream ready driver.
    initial begin
        out3x3_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) out3x3_rdy = ~out3x3_rdy;
            else               out3x3_rdy = 1'b1;
        end
    end

    // Monitor + model: consumes are checked against the model queue,
    // stalls must hold the output, acceptances feed the model.
    initial begin : monitor
        win_t act, snap, e;
        bit   stalled;
        int   r, c;
        stalled = 1'b0;
        snap    = '0;
        forever begin
            @(negedge clk);
            act = {out3x3_data, out3x3_sof, out3x3_sol, out3x3_eol, out3x3_eof};
            if (stalled) begin
                chk("stall_hold", {out3x3_val, act}, {1'b1, snap});
            end
            if (out3x3_val && !out3x3_rdy) begin
                chk("stall_in_rdy", in_rdy, 1'b0);
            end
            if (out3x3_val && out3x3_rdy) begin
                log_q.push_back(act);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_window: got %h, expected no window", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("window", act, e);
                end
            end
            stalled = out3x3_val && !out3x3_rdy && !rst;
            snap    = act;
            if (rst) begin
                m_row = 0;
                m_col = 0;
                exp_q.delete();
            end else if (in_val && in_rdy) begin
                c = in_sol ? 0 : m_col;
                r = in_sof ? 0 : m_row;
                if (r < 16 && c < 16) img[r][c] = int'(in_data);
                if (r >= 2 && c >= 2 && r < 16 && c < 16) begin
                    e = '0;
                    for (int dr = 0; dr < 3; dr++) begin
                        for (int dc = 0; dc < 3; dc++) begin
                            e.data[(8 - (3*dr + dc))*DW +: DW] = DW'(img[r-2+dr][c-2+dc]);
                        end
                    end
                    e.sof = (r == 2 && c == 2);
                    e.sol = (c == 2);
                    e.eol = in_eol;
                    e.eof = in_eof;
                    exp_q.push_back(e);
                end
                m_col = in_eol ? 0 : c + 1;
                m_row = in_eol ? r + 1 : r;
            end
        end
    end

    task automatic send_pix(input int d, input bit sof, input bit sol, input bit eol, input bit eof);
        int budget;
        bit done;
        budget  = 200;
        done    = 1'b0;
        in_val  = 1'b1;
        in_data = DW'(d);
        in_sof  = sof;
        in_sol  = sol;
        in_eol  = eol;
        in_eof  = eof;
        while (!done) begin
            @(negedge clk);
            if (in_rdy) done = 1'b1;
            @(posedge clk);
            #1;
            if (!done) begin
                budget--;
                if (budget == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL accept_timeout: got in_rdy=0 for 200 cycles, expected 1");
                    done = 1'b1;
                end
            end
        end
        in_val = 1'b0;
        in_sof = 1'b0;
        in_sol = 1'b0;
        in_eol = 1'b0;
        in_eof = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int base, input bit all_ff);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                send_pix(all_ff ? 255 : base + 10*r + c,
                         r == 0 && c == 0, c == 0, c == w-1, r == h-1 && c == w-1);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out3x3_val) break;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Hand-computed expectations for the 5x4 frame with pixel = 10*row+col.
    task automatic check_5x4(input string tag);
        chk({tag, "_count"}, log_q.size(), 6);
        chk({tag, "_first"}, log_q[0].data, 72'h00_01_02_0A_0B_0C_14_15_16);
        chk({tag, "_first_mk"}, {log_q[0].sof, log_q[0].sol, log_q[0].eol, log_q[0].eof}, 4'b1100);
        chk({tag, "_third"}, {log_q[2].eol, win_pix(log_q[2].data, P22)}, {1'b1, 8'd24});
        chk({tag, "_last"}, {log_q[5].eol, log_q[5].eof, win_pix(log_q[5].data, P22)}, {2'b11, 8'd34});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst     = 1'b1;
        in_val  = 1'b0;
        in_data = '0;
        in_sof  = 1'b0;
        in_sol  = 1'b0;
        in_eol  = 1'b0;
        in_eof  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_out", {out3x3_val, out3x3_sof, out3x3_sol, out3x3_eol, out3x3_eof, out3x3_data}, '0);
        chk("reset_in_rdy", in_rdy, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 5x4 frame, always ready.
        log_q.delete();
        send_frame(5, 4, 0, 1'b0);
        drain();
        check_5x4("s1");

        // Same frame with backpressure toggling.
        rdy_mode = 1;
        log_q.delete();
        send_frame(5, 4, 0, 1'b0);
        drain();
        check_5x4("s2");
        rdy_mode = 0;

        // Minimum 3x3 frame.
        log_q.delete();
        send_frame(3, 3, 0, 1'b0);
        drain();
        chk("s3_count", log_q.size(), 1);
        chk("s3_data", log_q[0].data, 72'h00_01_02_0A_0B_0C_14_15_16);
        chk("s3_mk", {log_q[0].sof, log_q[0].sol, log_q[0].eol, log_q[0].eof}, 4'b1111);

        // Too narrow: no windows.
        log_q.delete();
        send_frame(2, 4, 0, 1'b0);
        drain();
        chk("narrow_count", log_q.size(), 0);

        // All-0xFF frame followed by a normal frame.
        send_frame(5, 4, 0, 1'b1);
        drain();
        log_q.delete();
        send_frame(5, 4, 0, 1'b0);
        drain();
        check_5x4("s4");

        // Mid-frame sof at row 1 col 3.
        log_q.delete();
        for (int c = 0; c < 5; c++) send_pix(50 + c, c == 0, c == 0, c == 4, 1'b0);
        for (int c = 0; c < 3; c++) send_pix(60 + c, 1'b0, c == 0, 1'b0, 1'b0);
        send_frame(5, 4, 100, 1'b0);
        drain();
        chk("s5_count", log_q.size(), 6);
        chk("s5_first", log_q[0].data, 72'h64_65_66_6E_6F_70_78_79_7A);
        chk("s5_first_mk", {log_q[0].sof, log_q[0].sol}, 2'b11);

        // Reset at row 3 col 2 while a window is valid.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (!(r == 3 && c >= 3)) begin
                    send_pix(10*r + c, r == 0 && c == 0, c == 0, c == 4, 1'b0);
                end
            end
        end
        chk("s6_val_before_rst", out3x3_val, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s6_after_rst", {out3x3_val, out3x3_sof, out3x3_sol, out3x3_eol, out3x3_eof}, 5'b0);
        log_q.delete();
        send_frame(5, 4, 0, 1'b0);
        drain();
        check_5x4("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
